// File: rtl/mem_pkg.sv
// Shared types and default constants for the clearable dual-port memory.
package mem_pkg;

  // Controller state: IDLE serves user traffic, CLEAR owns the write port.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mem_state_t;

  // Default geometry: byte-wide data memory, 1024 words, cleared to zero.
  localparam int DEF_W       = 8;
  localparam int DEF_AW      = 10;
  localparam int DEF_CLR_VAL = 0;

endpackage

// File: rtl/mem_kxd_clr_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
// The storage array itself is never reset; only the output register is, so
// d_o comes up as zero without needing a pass over the array.
module ram_sdp #(
  parameter int W  = 8,
  parameter int AW = 10
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Array write; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Registered read; samples the pre-write word on a same-address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/mem_kxd_clr.sv
// Clearable W x 2**AW memory. A sweep sequencer writes CLR_VAL to every
// word after reset or on clr_req; while it runs, user reads and writes are
// dropped and busy is high.
module mem_kxd_clr
  import mem_pkg::*;
#(
  parameter int           W       = DEF_W,
  parameter int           AW      = DEF_AW,
  parameter logic [W-1:0] CLR_VAL = W'(DEF_CLR_VAL)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          busy,
  input  logic          wr,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  d_i,
  input  logic          rd,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  d_o,
  output logic          d_o_valid
);

  // Terminal sweep address; compared explicitly so the counter never wraps.
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  mem_state_t    r_state, w_state_nx;
  logic [AW-1:0] r_clr_addr, w_clr_addr_nx;
  logic          r_vld;

  logic          w_clearing;
  logic          w_last;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [W-1:0]  w_wdata;
  logic          w_re;

  assign w_clearing = (r_state == CLEAR);
  assign w_last     = (r_clr_addr == LAST_ADDR);

  // Next-state logic for the sweep FSM and its address counter.
  always_comb begin
    w_state_nx    = r_state;
    w_clr_addr_nx = r_clr_addr;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nx    = CLEAR;
          w_clr_addr_nx = '0;
        end
      end
      CLEAR: begin
        if (w_last) begin
          w_state_nx    = IDLE;
          w_clr_addr_nx = '0;
        end else begin
          w_clr_addr_nx = r_clr_addr + AW'(1);
        end
      end
    endcase
  end

  // Control registers; reset lands in CLEAR so contents become defined.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_clr_addr <= w_clr_addr_nx;
    end
  end

  // Write-port mux: the sweep owns the port while clearing, user otherwise.
  // A user write on the clr_req edge still lands because state is IDLE then.
  always_comb begin
    w_we    = wr;
    w_waddr = wr_addr;
    w_wdata = d_i;
    if (w_clearing) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = CLR_VAL;
    end
  end

  // Reads are only accepted in IDLE; otherwise d_o holds.
  assign w_re = rd & ~w_clearing;

  // Valid strobe tracks accepted reads with the same one-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vld <= 1'b0;
    else       r_vld <= w_re;
  end

  ram_sdp #(
    .W  (W),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .re    (w_re),
    .raddr (rd_addr),
    .rdata (d_o)
  );

  assign busy      = w_clearing;
  assign d_o_valid = r_vld;

endmodule

// File: tb/tb_mem_kxd_clr.sv
// Bench for mem_kxd_clr: a byte memory (W=8 AW=10 CLR_VAL=0) and a bit
// plane (W=1 AW=4 CLR_VAL=1) run side by side against a word-level model.
module tb_mem_kxd_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: byte memory
  logic       rst_a, clr_a, wr_a, rd_a, busy_a, vld_a;
  logic [9:0] wa_a, ra_a;
  logic [7:0] di_a, do_a;
  // Instance B: bit plane
  logic       rst_b, clr_b, wr_b, rd_b, busy_b, vld_b;
  logic [3:0] wa_b, ra_b;
  logic [0:0] di_b, do_b;

  mem_kxd_clr #(.W(8), .AW(10), .CLR_VAL(8'h00)) u_a (
    .clk(clk), .reset(rst_a), .clr_req(clr_a), .busy(busy_a),
    .wr(wr_a), .wr_addr(wa_a), .d_i(di_a),
    .rd(rd_a), .rd_addr(ra_a), .d_o(do_a), .d_o_valid(vld_a));

  mem_kxd_clr #(.W(1), .AW(4), .CLR_VAL(1'b1)) u_b (
    .clk(clk), .reset(rst_b), .clr_req(clr_b), .busy(busy_b),
    .wr(wr_b), .wr_addr(wa_b), .d_i(di_b),
    .rd(rd_b), .rd_addr(ra_b), .d_o(do_b), .d_o_valid(vld_b));

  int checks = 0;
  int errors = 0;

  // Reference model: word arrays plus "cycles of sweep remaining". A sweep
  // makes the whole array CLR_VAL; nothing can observe it part-way through.
  logic [7:0] ma [1024];
  int         rem_a;
  logic [7:0] eo_a;
  logic       ev_a;
  logic       mb [16];
  int         rem_b;
  logic       eo_b;
  logic       ev_b;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic reset_a();
    rem_a = 1024; eo_a = 8'h00; ev_a = 1'b0;
    foreach (ma[i]) ma[i] = 8'h00;
  endtask

  task automatic reset_b();
    rem_b = 16; eo_b = 1'b0; ev_b = 1'b0;
    foreach (mb[i]) mb[i] = 1'b1;
  endtask

  task automatic step_a();
    if (rem_a > 0) begin
      rem_a--; ev_a = 1'b0;
    end else begin
      ev_a = rd_a;
      if (rd_a) eo_a = ma[ra_a];
      if (wr_a) ma[wa_a] = di_a;
      if (clr_a) begin
        rem_a = 1024;
        foreach (ma[i]) ma[i] = 8'h00;
      end
    end
  endtask

  task automatic step_b();
    if (rem_b > 0) begin
      rem_b--; ev_b = 1'b0;
    end else begin
      ev_b = rd_b;
      if (rd_b) eo_b = mb[ra_b];
      if (wr_b) mb[wa_b] = di_b[0];
      if (clr_b) begin
        rem_b = 16;
        foreach (mb[i]) mb[i] = 1'b1;
      end
    end
  endtask

  // One clock: advance, update the model from the inputs seen at the edge,
  // compare every output of both instances.
  task automatic cycle();
    @(posedge clk); #1;
    if (rst_a) reset_a(); else step_a();
    if (rst_b) reset_b(); else step_b();
    chk("busy_a", busy_a, rem_a > 0);
    chk("vld_a",  vld_a,  ev_a);
    chk("do_a",   do_a,   eo_a);
    chk("busy_b", busy_b, rem_b > 0);
    chk("vld_b",  vld_b,  ev_b);
    chk("do_b",   do_b,   eo_b);
  endtask

  task automatic idle_in();
    clr_a = 0; wr_a = 0; rd_a = 0; wa_a = '0; ra_a = '0; di_a = '0;
    clr_b = 0; wr_b = 0; rd_b = 0; wa_b = '0; ra_b = '0; di_b = '0;
  endtask

  typedef struct {
    logic       wr;
    logic [9:0] wa;
    logic [7:0] d;
    logic       rd;
    logic [9:0] ra;
    logic       ev;
    logic [7:0] eo;
  } vec_t;

  vec_t tv [10];

  initial begin
    int na, nb, k;
    bit db;

    tv[0] = '{0, 10'h000, 8'h00, 1, 10'h000, 1, 8'h00};
    tv[1] = '{0, 10'h000, 8'h00, 1, 10'h1FF, 1, 8'h00};
    tv[2] = '{0, 10'h000, 8'h00, 1, 10'h3FF, 1, 8'h00};
    tv[3] = '{0, 10'h000, 8'h00, 0, 10'h000, 0, 8'h00};
    tv[4] = '{1, 10'h3FF, 8'hA5, 0, 10'h000, 0, 8'h00};
    tv[5] = '{0, 10'h000, 8'h00, 1, 10'h3FF, 1, 8'hA5};
    tv[6] = '{0, 10'h000, 8'h00, 0, 10'h000, 0, 8'hA5};
    tv[7] = '{1, 10'h005, 8'h11, 0, 10'h000, 0, 8'hA5};
    tv[8] = '{1, 10'h005, 8'h22, 1, 10'h005, 1, 8'h11};
    tv[9] = '{0, 10'h000, 8'h00, 1, 10'h005, 1, 8'h22};

    // Reset for 3 cycles, then time both initial sweeps.
    idle_in();
    rst_a = 1; rst_b = 1;
    reset_a(); reset_b();
    repeat (3) cycle();
    rst_a = 0; rst_b = 0;
    na = 0; nb = 0; db = 0;
    for (int i = 0; i < 1100 && busy_a; i++) begin
      cycle(); na++;
      if (!db && !busy_b) begin nb = na; db = 1; end
    end
    chk("sweep_len_a", na, 1024);
    chk("sweep_len_b", nb, 16);

    // Directed table on the byte memory.
    for (int i = 0; i < 10; i++) begin
      wr_a = tv[i].wr; wa_a = tv[i].wa; di_a = tv[i].d;
      rd_a = tv[i].rd; ra_a = tv[i].ra;
      cycle();
      chk($sformatf("tv%0d_vld", i), vld_a, tv[i].ev);
      chk($sformatf("tv%0d_do", i),  do_a,  tv[i].eo);
    end
    idle_in();

    // Bit plane: zero every word, request a clear, poke it during the sweep.
    for (int i = 0; i < 16; i++) begin
      wr_b = 1; wa_b = 4'(i); di_b = 1'b0;
      cycle();
    end
    wr_b = 0; rd_b = 1; ra_b = 4'd9;
    cycle();
    chk("zeroed_b", do_b, 0);
    rd_b = 0; clr_b = 1;
    cycle();
    clr_b = 0;
    for (k = 1; k <= 16; k++) begin
      wr_b = 1'($urandom); rd_b = 1'($urandom); di_b = 1'b0;
      wa_b = 4'($urandom); ra_b = 4'($urandom);
      cycle();
      chk("clr_busy_b", busy_b, k < 16);
      chk("clr_vld_b", vld_b, 0);
    end
    idle_in();
    for (int i = 0; i < 16; i++) begin
      rd_b = 1; ra_b = 4'(i);
      cycle();
      chk("after_clr_b", {vld_b, do_b}, 2'b11);
    end
    idle_in();
    cycle();

    // Reset mid-read: control drops at once, without waiting for an edge.
    rd_b = 1; ra_b = 4'd3;
    cycle();
    rd_b = 0; rst_b = 1; #1;
    chk("rst_read_busy", busy_b, 1);
    chk("rst_read_vld", vld_b, 0);
    chk("rst_read_do", do_b, 0);
    reset_b();
    cycle(); cycle();
    rst_b = 0;
    // Reset at sweep cycle 7, then the next sweep must be a full 16 cycles.
    repeat (7) cycle();
    rst_b = 1; #1;
    chk("rst_sweep_busy", busy_b, 1);
    chk("rst_sweep_vld", vld_b, 0);
    reset_b();
    cycle(); cycle();
    rst_b = 0;
    nb = 0;
    for (int i = 0; i < 40 && busy_b; i++) begin cycle(); nb++; end
    chk("rst_sweep_len", nb, 16);

    // Second clr_req mid-sweep must not restart the sweep.
    clr_b = 1;
    cycle();
    clr_b = 0;
    nb = 0;
    for (int i = 1; i <= 40 && busy_b; i++) begin
      clr_b = (i == 5);
      cycle(); nb++;
    end
    clr_b = 0;
    chk("no_restart_len", nb, 16);

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_a = 1'($urandom); rd_a = 1'($urandom); di_a = 8'($urandom);
      wa_a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
      ra_a = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
      clr_a = ($urandom_range(0, 799) == 0);
      wr_b = 1'($urandom); rd_b = 1'($urandom); di_b = 1'($urandom);
      wa_b = 4'($urandom); ra_b = 4'($urandom);
      clr_b = ($urandom_range(0, 59) == 0);
      cycle();
    end
    idle_in();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_kxd_clr.md
Name: mem_kxd_clr

Overview:
Parametrised successor to the 1-bit x 1024 display memory: a W-bit x 2**AW simple dual-port RAM with synchronous read-first output and a read-valid strobe. It adds a hardware clear sequencer that sweeps every address to CLR_VAL after reset or on request, so RAM contents are well-defined without initial blocks. It serves as both the byte data memory (W=8) and the display bit-plane (W=1).

Parameters:
W, 8, data width in bits (1 for display use)
AW, 10, address width; DEPTH = 2**AW words
CLR_VAL, 0, W-bit value written to every word by the clear sweep

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
clr_req  input  1  one-cycle request to start a clear sweep
busy  output  1  high while the clear sweep runs
wr  input  1  write enable
wr_addr  input  AW  write address
d_i  input  W  write data
rd  input  1  read enable
rd_addr  input  AW  read address
d_o  output  W  registered read data
d_o_valid  output  1  one-cycle strobe: d_o updated by an accepted read

Behaviour:
- Clock/reset: one clock clk; reset is asynchronous, active-high. Reset affects control registers only; the RAM array has no reset.
- Reset values: state=CLEAR, clr_addr=0, busy=1, d_o=0, d_o_valid=0.
- States: IDLE, CLEAR.
- IDLE: busy=0. Write: wr=1 at edge -> mem[wr_addr]<=d_i. Read: rd=1 at edge -> d_o<=mem[rd_addr], d_o_valid<=1 at the same edge. rd=0 -> d_o holds, d_o_valid<=0.
- Read latency: 1 cycle (address sampled at edge N, data and strobe visible after edge N).
- Read and write to the same address at the same edge: read-first. d_o gets the old word; the new word is visible on the next read.
- clr_req=1 in IDLE at edge N: a user write at that edge still completes. State becomes CLEAR with clr_addr=0 and busy=1 after edge N.
- CLEAR: each edge writes mem[clr_addr]<=CLR_VAL and increments clr_addr. The edge that writes DEPTH-1 returns to IDLE, clears busy, and resets clr_addr to 0. The sweep takes exactly DEPTH cycles.
- After reset release, the first edge writes address 0. busy falls after edge DEPTH.
- During CLEAR:
  - wr is ignored; the data is dropped.
  - rd is ignored; d_o holds and d_o_valid=0.
  - clr_req is ignored; the sweep is not restarted.
- Reset asserted mid-sweep or mid-read: control returns immediately to reset values. A new sweep starts from address 0.
- Address wrap: clr_addr is AW+1 bits or has an explicit terminal compare. The sweep must not wrap and re-clear.
- Widths: user addresses are AW bits, so every address is in range. No truncation or extension is performed on data.

Decomposition:
- Package mem_pkg holds:
  - typedef enum logic {IDLE, CLEAR} mem_state_t
  - the default parameter constants (W, AW, CLR_VAL).
- Sub-module ram_sdp (W, AW): plain array, one write port, one registered read port, read-first, no reset.
- The top level holds the FSM and clr_addr counter, muxes the write port between the sweep and the user, and gates rd and the valid strobe.

Test Plan:
- Reset held for 3 cycles then released, W=8 AW=10: busy=1 for exactly 1024 cycles, then 0. A read of addr 0, 511 and 1023 returns 8'h00 with d_o_valid pulsed for one cycle.
- Idle traffic: write 8'hA5 to 10'h3FF, then rd 10'h3FF next cycle. d_o=8'hA5 one cycle later; d_o_valid high exactly 1 cycle.
- Read/write collision: mem[5]=8'h11, then wr=1 d_i=8'h22 with rd=1 at addr 5 on the same edge. d_o=8'h11; a following read of addr 5 gives 8'h22.
- clr_req with W=1 AW=4 CLR_VAL=1 after writing 0 to all 16 words:
  - busy stays high 16 cycles.
  - wr and rd issued during the sweep have no effect; d_o_valid stays 0.
  - Afterwards all 16 words read 1.
- Reset asserted at sweep cycle 7 (AW=4): busy stays 1 and d_o_valid=0 immediately. After release, the sweep takes a full 16 cycles from addr 0.
- clr_req pulsed again mid-sweep (AW=4): busy falls exactly 16 cycles after the original request (no restart).
